// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate formats, base opcodes and AUTO format resolution
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_S     = 3'd1,
        FMT_B     = 3'd2,
        FMT_U     = 3'd3,
        FMT_J     = 3'd4,
        FMT_SHAMT = 3'd5,
        FMT_AUTO  = 3'd6,
        FMT_RSVD  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Opcodes without an immediate resolve to FMT_RSVD so they share the error path.
    function automatic fmt_e resolve_auto(input logic [31:0] instr);
        fmt_e f;
        case (instr[6:0])
            OP_IMM, OP_IMM32: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                    f = FMT_SHAMT;
                else
                    f = FMT_I;
            end
            OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:          f = FMT_S;
            OP_BRANCH:         f = FMT_B;
            OP_LUI, OP_AUIPC:  f = FMT_U;
            OP_JAL:            f = FMT_J;
            default:           f = FMT_RSVD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// rtl/imm_gen_core.sv - combinational immediate extraction and extension to XLEN
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    fmt_e f;
    logic fill;

    always_comb begin
        f = fmt_e'(fmt);
        if (f == FMT_AUTO)
            f = resolve_auto(instr);
        fill = SIGN_EXT & instr[31];
        imm  = '0;
        err  = 1'b0;
        case (f)
            FMT_I: imm = {{(XLEN-12){fill}}, instr[31:20]};
            FMT_S: imm = {{(XLEN-12){fill}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(XLEN-13){fill}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            // U is always sign-extended so LUI/AUIPC keep their RV64 meaning.
            FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = {{(XLEN-21){fill}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            FMT_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with valid/ready handshake and 2-entry output buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  core_imm;
    logic             core_err;

    imm_gen_core #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_core (
        .instr (in_instr),
        .fmt   (in_fmt),
        .imm   (core_imm),
        .err   (core_err)
    );

    logic [XLEN-1:0]  imm_q [2];
    logic             err_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                err_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            if (push) begin
                imm_q[wptr] <= core_imm;
                err_q[wptr] <= core_err;
                tag_q[wptr] <= in_tag;
                wptr        <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Idle outputs read as zero rather than exposing a stale entry.
    assign out_imm = out_valid ? imm_q[rptr] : '0;
    assign out_err = out_valid ? err_q[rptr] : 1'b0;
    assign out_tag = out_valid ? tag_q[rptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and randomized checks of imm_gen_pipe against a reference model
`timescale 1ns/1ps
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, out_err_s;
    logic [31:0] out_imm_s;
    logic [3:0]  out_tag_s;
    logic        in_ready_z, out_valid_z, out_err_z;
    logic [31:0] out_imm_z;
    logic [3:0]  out_tag_z;
    logic        in_ready_w, out_valid_w, out_err_w;
    logic [63:0] out_imm_w;
    logic [3:0]  out_tag_w;

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_imm(out_imm_s),
        .out_err(out_err_s), .out_tag(out_tag_s)
    );

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b0), .TAG_W(4)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid_z), .out_ready(out_ready), .out_imm(out_imm_z),
        .out_err(out_err_z), .out_tag(out_tag_z)
    );

    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1), .TAG_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_imm(out_imm_w),
        .out_err(out_err_w), .out_tag(out_tag_w)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: pick the field bits, then extend arithmetically by subtracting 2^width.
    function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt,
                                            input int xlen, input bit sext);
        int     f;
        int     w;
        bit     ext;
        longint v;
        f = int'(fmt);
        if (f == 6) begin
            case (ins[6:0])
                7'h13, 7'h1B: f = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 5 : 0;
                7'h03, 7'h67: f = 0;
                7'h23:        f = 1;
                7'h63:        f = 2;
                7'h37, 7'h17: f = 3;
                7'h6F:        f = 4;
                default:      f = 7;
            endcase
        end
        ext = sext;
        v = 0;
        w = 1;
        case (f)
            0: begin v = ins[31:20]; w = 12; end
            1: begin v = {ins[31:25], ins[11:7]}; w = 12; end
            2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; w = 13; end
            3: begin v = {ins[31:12], 12'b0}; w = 32; ext = 1'b1; end
            4: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; w = 21; end
            5: begin v = (xlen == 64) ? ins[25:20] : ins[24:20]; w = 6; ext = 1'b0; end
            default: return {1'b1, 64'd0};
        endcase
        if (ext && v[w-1])
            v = v - (longint'(1) << w);
        if (xlen == 32)
            v = v & 64'h0000_0000_FFFF_FFFF;
        return {1'b0, v};
    endfunction

    typedef struct {
        logic [63:0] s;
        logic [63:0] z;
        logic [63:0] w;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [64:0] r_s, r_z, r_w;
    int          npop = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_s && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    npop++;
                    check("sb_imm_sext32", out_imm_s, mon_e.s);
                    check("sb_imm_zext32", out_imm_z, mon_e.z);
                    check("sb_imm_sext64", out_imm_w, mon_e.w);
                    check("sb_err", {out_err_s, out_err_z, out_err_w}, {3{mon_e.err}});
                    check("sb_tag", {out_tag_s, out_tag_z, out_tag_w}, {3{mon_e.tag}});
                    check("sb_valid_sync", {out_valid_z, out_valid_w}, 2'b11);
                end
            end
            if (in_valid && in_ready_s) begin
                check("sb_ready_sync", {in_ready_z, in_ready_w}, 2'b11);
                r_s = ref_imm(in_instr, in_fmt, 32, 1'b1);
                r_z = ref_imm(in_instr, in_fmt, 32, 1'b0);
                r_w = ref_imm(in_instr, in_fmt, 64, 1'b1);
                exp_q.push_back('{s: r_s[63:0], z: r_z[63:0], w: r_w[63:0],
                                  err: r_s[64], tag: in_tag});
            end
        end
    end

    logic [3:0] tag_ctr;

    task automatic send(input logic [31:0] ins, input logic [2:0] f, output int cyc);
        bit ok;
        cyc = 0;
        in_instr = ins;
        in_fmt   = f;
        in_tag   = tag_ctr;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready_s;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 64);
        check("send_accepted", ok, 1'b1);
        tag_ctr = tag_ctr + 4'd1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] auto_ins [4] = '{32'hFE20AE23, 32'h00000463, 32'h123450B7, 32'hFFDFF06F};
    logic [31:0] auto_exp [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFFFFC};
    logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          pop_base;
        logic [3:0]  t0;
        logic [31:0] r;
        logic [2:0]  f;
        bit          rand_done;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_fmt = '0; in_tag = '0;
        out_ready = 1'b0; tag_ctr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_s, 1'b0);
        check("rst_out_imm", out_imm_s, 32'd0);
        check("rst_out_err", out_err_s, 1'b0);
        check("rst_out_tag", out_tag_s, 4'd0);
        check("rst_in_ready", in_ready_s, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // I-type, one cycle latency, both extension modes
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, cyc);
        in_valid = 1'b0;
        check("i_latency_valid", out_valid_s, 1'b1);
        check("i_imm_sext", out_imm_s, 32'hFFFFFFFF);
        check("i_imm_zext", out_imm_z, 32'h00000FFF);
        check("i_imm_64", out_imm_w, 64'hFFFFFFFFFFFFFFFF);
        check("i_err", out_err_s, 1'b0);
        idle(1);

        // AUTO back-to-back, one beat per cycle
        for (int i = 0; i < 4; i++) begin
            t0 = tag_ctr;
            send(auto_ins[i], 3'd6, cyc);
            check("auto_accept_cycles", cyc, 1);
            check("auto_valid", out_valid_s, 1'b1);
            check("auto_imm", out_imm_s, auto_exp[i]);
            check("auto_tag", out_tag_s, t0);
        end
        idle(2);
        check("auto_drained", out_valid_s, 1'b0);

        // Backpressure: two beats fill the buffer, the third waits
        out_ready = 1'b0;
        pop_base = npop;
        t0 = tag_ctr;
        send(32'h80000013, 3'd0, cyc);
        send(32'h00500093, 3'd0, cyc);
        fork
            send(32'h00100463, 3'd2, cyc);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready_s, 1'b0);
                    check("bp_head_tag", out_tag_s, t0);
                    check("bp_head_imm", out_imm_s, 32'hFFFFF800);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);
        check("bp_pop_count", npop - pop_base, 3);
        check("bp_sb_empty", exp_q.size(), 0);

        // Error beats keep their tag
        r = $urandom();
        t0 = tag_ctr;
        send(r, 3'd7, cyc);
        check("rsvd_err", out_err_s, 1'b1);
        check("rsvd_imm", out_imm_s, 32'd0);
        check("rsvd_tag", out_tag_s, t0);
        t0 = tag_ctr;
        send(32'h00000033, 3'd6, cyc);
        check("auto_rtype_err", out_err_s, 1'b1);
        check("auto_rtype_imm", out_imm_s, 32'd0);
        check("auto_rtype_tag", out_tag_s, t0);

        // XLEN=64 specifics
        send(32'h800000B7, 3'd3, cyc);
        check("u64_imm", out_imm_w, 64'hFFFFFFFF80000000);
        check("u32_zext_imm", out_imm_z, 32'h80000000);
        send(32'h03F00013, 3'd5, cyc);
        check("shamt64_imm", out_imm_w, 64'h000000000000003F);
        check("shamt32_imm", out_imm_s, 32'h0000001F);
        idle(2);

        // Random traffic with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    r = $urandom();
                    if ($urandom_range(0, 9) == 0)
                        r[6:0] = r[6:0];
                    else
                        r[6:0] = ops[$urandom_range(0, 9)];
                    f = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1)
                        f = 3'd6;
                    send(r, f, cyc);
                    if ($urandom_range(0, 4) == 0)
                        idle(1);
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(4);
        check("rand_sb_empty", exp_q.size(), 0);

        // Reset while the buffer is full
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, cyc);
        send(32'h00200093, 3'd0, cyc);
        in_valid = 1'b0;
        check("mid_full", in_ready_s, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid_s, 1'b0);
        check("mid_rst_imm", out_imm_s, 32'd0);
        check("mid_rst_imm64", out_imm_w, 64'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", in_ready_s, 1'b1);
        check("post_rst_empty", out_valid_s, 1'b0);
        out_ready = 1'b1;
        t0 = tag_ctr;
        send(32'h7FF00093, 3'd0, cyc);
        in_valid = 1'b0;
        check("post_rst_valid", out_valid_s, 1'b1);
        check("post_rst_imm", out_imm_s, 32'h000007FF);
        check("post_rst_tag", out_tag_s, t0);
        idle(1);
        check("post_rst_alone", out_valid_s, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. Supports all RV32/RV64 immediate formats (I, S, B, U, J, shift-amount), plus an opcode-driven auto-decode mode, with selectable sign- or zero-extension to XLEN. Sits between instruction fetch/decode and the execute stage. Uses a valid/ready handshake and a 2-entry output buffer, so the block gives full throughput under backpressure.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
SIGN_EXT, 1, 1 = sign-extend from the format's top immediate bit; 0 = zero-extend (legacy-compatible mode).
TAG_W, 4, width of the sideband tag carried alongside each instruction.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_instr  in  32  raw instruction word.
in_fmt  in  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 AUTO, 7 reserved.
in_tag  in  TAG_W  sideband tag, passed through unchanged.
out_valid  out  1  output beat valid.
out_ready  in  1  consumer accepts the beat.
out_imm  out  XLEN  generated immediate.
out_err  out  1  illegal format, or AUTO with an opcode that has no immediate.
out_tag  out  TAG_W  tag of the current output beat.

Behaviour:
- Reset (rst_n low, asynchronous): buffer count = 0, out_valid = 0, out_imm = 0, out_err = 0, out_tag = 0, in_ready = 1 once reset is released. Any entries held when reset asserts mid-operation are discarded; the first beat after reset sees an empty buffer.
- Handshake:
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - Inputs must stay stable while in_valid is high and in_ready is low.
  - Outputs stay stable while out_valid is high and out_ready is low.
- Latency: a beat pushed at edge t is presented on out_* immediately after edge t (1 cycle). Throughput is 1 beat/cycle when out_ready is held high.
- Buffer: 2-entry FIFO holding {imm, err, tag}. Each entry's immediate is computed combinationally from in_instr/in_fmt and captured at push.
  - in_ready = (count < 2). This is a registered-count decode; there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). Head entry drives out_*.
  - count 1, simultaneous push and pop: count stays 1; the new entry becomes head on the next cycle.
  - count 2: no push possible; a pop makes count 1.
  - count 0: a pop is impossible because out_valid = 0.
  - Read/write pointers are 1 bit each and wrap naturally.
- Immediate assembly (before extension), with s = instr[31]:
  - I: instr[31:20], 12 bits.
  - S: {instr[31:25], instr[11:7]}, 12 bits.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, 13 bits.
  - U: {instr[31:12], 12'b0}, 32 bits. Sign-extended to XLEN=64 regardless of SIGN_EXT.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, 21 bits.
  - SHAMT: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. Always zero-extended.
- Extension: SIGN_EXT=1 replicates the top immediate bit up to XLEN-1; SIGN_EXT=0 fills with zeros (U is the exception noted above).
- AUTO (fmt 6) decodes instr[6:0]:
  - 0010011, 0000011, 1100111, 0011011 → I. For 0010011/0011011 with funct3 = 001 or 101 → SHAMT.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → imm = 0, err = 1.
- fmt 7: imm = 0, err = 1. The beat still flows through the buffer; it is never dropped.
- Tag is carried unmodified, in order.

Decomposition:
- Shared package imm_pkg:
  - fmt_e enum (FMT_I..FMT_RSVD).
  - Opcode constants (OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
  - Function resolving AUTO to fmt_e.
- One sub-module: imm_gen_core, purely combinational. Inputs instr, fmt; outputs imm[XLEN-1:0], err. Parametrised by XLEN and SIGN_EXT.
- The top level holds the 2-entry buffer and the handshake.

Test Plan:
1. I-type: instr 0xFFF00093, fmt 0, SIGN_EXT=1, XLEN=32 → out_imm 0xFFFFFFFF, err 0, one cycle after push. With SIGN_EXT=0 → 0x00000FFF.
2. All formats via AUTO, back-to-back, out_ready=1:
   - 0xFE20AE23 → 0xFFFFFFFC
   - 0x00000463 → 0x00000008
   - 0x123450B7 → 0x12345000
   - 0xFFDFF06F → 0xFFFFFFFC
   - Required: 4 output beats on 4 consecutive cycles, tags in order.
3. Backpressure: out_ready=0 with 3 beats offered → in_ready drops after 2 pushes; the head is held stable. Raise out_ready → both buffered beats drain in order, then the third is accepted, with no loss or duplication.
4. Errors:
   - fmt 7 with any instr → imm 0, err 1.
   - AUTO with 0x00000033 (R-type) → imm 0, err 1.
   - In both cases the tag is preserved.
5. XLEN=64:
   - U 0x800000B7 → 0xFFFFFFFF80000000.
   - SHAMT with instr[25:20]=0x3F → 0x000000000000003F.
6. Reset mid-operation: buffer full, assert rst_n low asynchronously between edges → out_valid falls immediately, out_imm 0. After release, in_ready=1 and the next beat emerges alone.
